// File: rtl/regfile_dump_reader_if.sv
// Output stream of the register-file dump reader.
// Carries the word, its register index, last marker and valid/ready.
interface regfile_dump_reader_if #(
  parameter int ADDR_W = 5
);
  logic [31:0]       out_data;
  logic [ADDR_W-1:0] out_index;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out_data,
    output out_index,
    output out_last,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_index,
    input  out_last,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks the register file through one read port and streams every word.
// REGDUMP_CHECKSUM_EN appends an XOR checksum word to each dump.
module regfile_dump_reader #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  regfile_dump_reader_if.master dump,
  output logic              busy,
  output logic              done
);

`ifdef REGDUMP_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE, READ, SEND, CSUM, FIN
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, READ, SEND, FIN
  } state_t;
`endif

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(NUM_REGS - 1);

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       data_q;
  logic [ADDR_W-1:0] index_q;
  logic              hs;
  logic              at_last;

  assign hs      = dump.out_valid & dump.out_ready;
  assign at_last = (idx == LAST);
  assign rd_addr = idx;
  assign busy    = (state != IDLE);
  assign done    = (state == FIN);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start) state_n = READ;
      READ: state_n = SEND;
      SEND: begin
        if (hs) begin
`ifdef REGDUMP_CHECKSUM_EN
          state_n = at_last ? CSUM : READ;
`else
          state_n = at_last ? FIN : READ;
`endif
        end
      end
`ifdef REGDUMP_CHECKSUM_EN
      CSUM: if (hs) state_n = FIN;
`endif
      FIN:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      data_q  <= '0;
      index_q <= '0;
    end else begin
      if (state == IDLE && start)
        idx <= '0;
      if (state == READ) begin
        data_q  <= rd_data;
        index_q <= idx;
      end
      if (state == SEND && hs && !at_last)
        idx <= idx + 1'b1;
    end
  end

`ifdef REGDUMP_CHECKSUM_EN
  logic [31:0] csum;
  logic        in_csum;

  always_ff @(posedge clk) begin
    if (rst)
      csum <= '0;
    else if (state == IDLE && start)
      csum <= '0;
    else if (state == READ)
      csum <= csum ^ rd_data;
  end

  // The checksum word is presented straight from the accumulator.
  assign in_csum        = (state == CSUM);
  assign dump.out_valid = (state == SEND) | in_csum;
  assign dump.out_data  = in_csum ? csum : data_q;
  assign dump.out_index = in_csum ? '0 : index_q;
  assign dump.out_last  = in_csum;
`else
  logic last_q;

  always_ff @(posedge clk) begin
    if (rst)
      last_q <= 1'b0;
    else if (state == READ)
      last_q <= at_last;
  end

  assign dump.out_valid = (state == SEND);
  assign dump.out_data  = data_q;
  assign dump.out_index = index_q;
  assign dump.out_last  = last_q;
`endif

endmodule

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Debug read-out engine for the 32×32-bit RISC-V register file. On a start request it walks every register through one read-address port and captures the asynchronous read data. It streams each word out over a valid/ready interface, then pulses done. It sits beside the datapath and shares a read port with the debug or UART path, so register contents can be inspected without halting writes.

## Interface
- NUM_REGS, 32, number of registers dumped, starting at address 0 (2..32).
- ADDR_W, 5, register address width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  dump request; sampled only in IDLE.
- rd_addr  out  ADDR_W  read address to the register file port.
- rd_data  in  32  combinational read data for rd_addr.
- out_data  out  32  captured word.
- out_index  out  ADDR_W  register number of out_data; 0 for the checksum word.
- out_last  out  1  marks the final word of the dump.
- out_valid  out  1  out_data, out_index and out_last are valid.
- out_ready  in  1  consumer accepts the word when both out_valid and out_ready are high.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the final handshake.

## Operation
- FSM states are IDLE, READ, SEND, CSUM and FIN.
- IDLE:
  - If start=1, clear idx to 0, clear csum to 0, and go to READ.
  - Otherwise stay in IDLE.
- READ:
  - rd_addr = idx.
  - At the clock edge, load out_data←rd_data and out_index←idx, and update csum←csum^rd_data.
  - Set out_last = (idx==NUM_REGS-1) when the macro is off. When the macro is on, out_last is 0 here.
  - Go to SEND.
- SEND:
  - out_valid=1. Hold out_data, out_index and out_last stable until the handshake.
  - On handshake:
    - If idx==NUM_REGS-1, go to CSUM when the macro is on, otherwise to FIN.
    - Else idx←idx+1 and go to READ.
- CSUM (macro on only):
  - out_valid=1, out_data=csum, out_index=0, out_last=1.
  - On handshake, go to FIN.
- FIN: done=1 for exactly one cycle, then go to IDLE.
- rd_addr always equals idx and is driven in every state.
- Register writes during a dump are not blocked. The value captured is the register's content in that word's READ cycle.
- start is ignored while busy=1. A start arriving in FIN is also ignored.

## Timing
- Reset values:
  - out_valid=0, out_last=0, done=0, busy=0.
  - out_data=0, out_index=0, rd_addr=0.
  - csum=0, idx=0, state=IDLE.
- rst asserted in any state (including mid-handshake) returns the block to reset values on that edge. No partial word is re-presented afterwards.
- Latency from start (IDLE edge) to first out_valid is 2 cycles: IDLE→READ→SEND.
- With out_ready held high, each word takes 2 cycles (READ, SEND).
- A full 32-word dump with out_ready held high takes 64 cycles from the first READ to the last handshake. FIN follows in the next cycle.
- Backpressure: out_valid never drops without a handshake, and no output changes while out_valid=1 and out_ready=0.
- done is asserted the cycle after the final handshake and busy is still 1 during it. busy falls in the following cycle.
- idx never wraps: NUM_REGS-1 is terminal.

## Configuration
- Macro: REGDUMP_CHECKSUM_EN.
- When defined:
  - CSUM state exists.
  - After NUM_REGS register words, one extra word equal to the XOR of all captured words is sent with out_last=1 and out_index=0.
  - Dump length is NUM_REGS+1 words.
- When undefined:
  - CSUM state and csum register are absent.
  - out_last is set on word NUM_REGS-1.
  - Dump length is NUM_REGS words.

## Test plan
- Reset check: preload reg i=i for all i, reg5=0xDEADBEEF, then pulse start with out_ready=1. Required: 32 words in index order 0..31 with matching data, the first out_valid exactly 2 cycles after start, done 1 cycle after the last handshake, and 64 cycles from the first READ to the last handshake.
- Checksum (REGDUMP_CHECKSUM_EN on): same preload. Required: a 33rd word 0xDEADBEEA with out_index=0 and out_last=1. With the macro off, word 31 (data 31) carries out_last=1.
- Backpressure: toggle out_ready randomly, with a 10-cycle stall on word 7 (value 7). Required: out_data=7 and out_index=7 are held stable for the whole stall, with no duplicated or dropped words.
- Start while busy: pulse start during word 3 and again during FIN. Required: exactly one dump, one done pulse, and busy=0 afterwards.
- Mid-dump reset: assert rst while SEND holds word 10. Required: on the next edge out_valid=0, busy=0 and rd_addr=0. A new start then dumps from index 0.
- Concurrent write: write 0x12345678 to reg 20 during the dump's READ of reg 19. Required: the dumped reg 20 equals 0x12345678.
